// File: rtl/anc_tap_sched.sv
`default_nettype none
// ============================================================================
// Module   : anc_tap_sched
// Purpose  : per-sample strobe sequencer for a time-multiplexed ANC FIR/LMS
//            datapath; optional ANC_FREEZE_EN adds a wfreeze input (skip UPD)
// Revision : 1.0 - initial release
// ============================================================================
module anc_tap_sched #(
   parameter int NTAP   = 3,
   parameter int AW     = 4,
   parameter int W2     = 4,
   parameter int MU_RST = 8,
   parameter int MU_MAX = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          smp_valid,
   input  logic [W2-1:0] mu_in,
   input  logic          mu_ld,
   input  logic          ovr_clr,
`ifdef ANC_FREEZE_EN
   input  logic          wfreeze,
`endif
   output logic          shift_en,
   output logic [AW-1:0] tap_addr,
   output logic          mac_clr,
   output logic          mac_en,
   output logic          err_ld,
   output logic          wupd_en,
   output logic [W2-1:0] mu_out,
   output logic          anc_valid,
   output logic          busy,
   output logic          overrun
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      FILT  = 3'd2,
      ERR   = 3'd3,
      UPD   = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [AW-1:0] C_LAST_TAP = AW'(NTAP - 1);
   localparam logic [W2-1:0] C_MU_MAX   = W2'(MU_MAX);
   localparam logic [W2-1:0] C_MU_RST   = W2'(MU_RST);

   state_t        state_q, state_d;
   logic [AW-1:0] tap_q, tap_d;
   logic [W2-1:0] mu_q, mu_d;
   logic [W2-1:0] mu_pend_q, mu_pend_d;
   logic          pend_vld_q, pend_vld_d;
   logic          ovr_q, ovr_d;
   logic          shift_q, shift_d;
   logic          mac_q, mac_d;
   logic          clr_q, clr_d;
   logic          err_q, err_d;
   logic          wupd_q, wupd_d;
   logic          valid_q, valid_d;

   logic [W2-1:0] w_mu_clamp;
   logic          w_freeze;
   logic          w_enter_idle;

`ifdef ANC_FREEZE_EN
   assign w_freeze = wfreeze;
`else
   assign w_freeze = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      if (en) begin
         case (state_q)
            IDLE: begin
               tap_d = '0;
               if (smp_valid) state_d = SHIFT;
            end
            SHIFT: begin
               state_d = FILT;
               tap_d   = '0;
            end
            FILT: begin
               if (tap_q == C_LAST_TAP) begin
                  state_d = ERR;
                  tap_d   = '0;
               end else begin
                  tap_d = tap_q + 1'b1;
               end
            end
            ERR: begin
               state_d = w_freeze ? DONE : UPD;
               tap_d   = '0;
            end
            UPD: begin
               if (tap_q == C_LAST_TAP) begin
                  state_d = DONE;
                  tap_d   = '0;
               end else begin
                  tap_d = tap_q + 1'b1;
               end
            end
            DONE: begin
               state_d = IDLE;
               tap_d   = '0;
            end
            default: begin
               state_d = IDLE;
               tap_d   = '0;
            end
         endcase
      end
   end

   // Strobes are decoded from the next state so they line up with it as flops.
   always_comb begin
      shift_d = (state_d == SHIFT);
      mac_d   = (state_d == FILT);
      clr_d   = (state_d == FILT) && (tap_d == '0);
      err_d   = (state_d == ERR);
      wupd_d  = (state_d == UPD);
      valid_d = (state_d == DONE);
   end

   always_comb begin
      ovr_d = (smp_valid && en && (state_q != IDLE)) || (ovr_q && !ovr_clr);
   end

   // Mu changes only in IDLE or on the edge returning to it, never mid-update.
   always_comb begin
      w_mu_clamp   = (mu_in > C_MU_MAX) ? C_MU_MAX : mu_in;
      w_enter_idle = (state_q != IDLE) && (state_d == IDLE);
      mu_d         = mu_q;
      mu_pend_d    = mu_pend_q;
      pend_vld_d   = pend_vld_q;
      if (state_q == IDLE) begin
         if (mu_ld) mu_d = w_mu_clamp;
      end else if (w_enter_idle) begin
         mu_d       = mu_ld ? w_mu_clamp : (pend_vld_q ? mu_pend_q : mu_q);
         pend_vld_d = 1'b0;
      end else if (mu_ld) begin
         mu_pend_d  = w_mu_clamp;
         pend_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         tap_q      <= '0;
         mu_q       <= C_MU_RST;
         mu_pend_q  <= '0;
         pend_vld_q <= 1'b0;
         ovr_q      <= 1'b0;
         shift_q    <= 1'b0;
         mac_q      <= 1'b0;
         clr_q      <= 1'b0;
         err_q      <= 1'b0;
         wupd_q     <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         tap_q      <= tap_d;
         mu_q       <= mu_d;
         mu_pend_q  <= mu_pend_d;
         pend_vld_q <= pend_vld_d;
         ovr_q      <= ovr_d;
         shift_q    <= shift_d;
         mac_q      <= mac_d;
         clr_q      <= clr_d;
         err_q      <= err_d;
         wupd_q     <= wupd_d;
         valid_q    <= valid_d;
      end
   end

   assign shift_en  = shift_q & en;
   assign mac_en    = mac_q & en;
   assign mac_clr   = clr_q & en;
   assign err_ld    = err_q & en;
   assign wupd_en   = wupd_q & en;
   assign anc_valid = valid_q & en;
   assign tap_addr  = tap_q;
   assign mu_out    = mu_q;
   assign busy      = (state_q != IDLE);
   assign overrun   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_anc_tap_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_anc_tap_sched
// Purpose  : directed cycle-by-cycle checks of anc_tap_sched (NTAP=3)
// Revision : 1.0 - initial release
// ============================================================================
module tb_anc_tap_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       smp_valid;
   logic [3:0] mu_in;
   logic       mu_ld;
   logic       ovr_clr;
`ifdef ANC_FREEZE_EN
   logic       wfreeze;
`endif
   logic       shift_en;
   logic [3:0] tap_addr;
   logic       mac_clr;
   logic       mac_en;
   logic       err_ld;
   logic       wupd_en;
   logic [3:0] mu_out;
   logic       anc_valid;
   logic       busy;
   logic       overrun;

   int n_checks = 0;
   int n_fail   = 0;

   always #50 clk = ~clk;

   anc_tap_sched #(
      .NTAP(3), .AW(4), .W2(4), .MU_RST(8), .MU_MAX(12)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .smp_valid (smp_valid),
      .mu_in     (mu_in),
      .mu_ld     (mu_ld),
      .ovr_clr   (ovr_clr),
`ifdef ANC_FREEZE_EN
      .wfreeze   (wfreeze),
`endif
      .shift_en  (shift_en),
      .tap_addr  (tap_addr),
      .mac_clr   (mac_clr),
      .mac_en    (mac_en),
      .err_ld    (err_ld),
      .wupd_en   (wupd_en),
      .mu_out    (mu_out),
      .anc_valid (anc_valid),
      .busy      (busy),
      .overrun   (overrun)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   // Nominal per-cycle outputs after a sample in cycle 0:
   // {shift_en, mac_en, mac_clr, err_ld, wupd_en, anc_valid, busy, tap_addr[3:0]}
   function automatic logic [10:0] nom(input int c);
      case (c)
         1:       return 11'b100000_1_0000;
         2:       return 11'b011000_1_0000;
         3:       return 11'b010000_1_0001;
         4:       return 11'b010000_1_0010;
         5:       return 11'b000100_1_0000;
         6:       return 11'b000010_1_0000;
         7:       return 11'b000010_1_0001;
         8:       return 11'b000010_1_0010;
         9:       return 11'b000001_1_0000;
         default: return 11'b000000_0_0000;
      endcase
   endfunction

   task automatic drive_idle();
      reset     = 1'b0;
      en        = 1'b1;
      smp_valid = 1'b0;
      mu_in     = 4'd0;
      mu_ld     = 1'b0;
      ovr_clr   = 1'b0;
`ifdef ANC_FREEZE_EN
      wfreeze   = 1'b0;
`endif
   endtask

   task automatic do_reset();
      drive_idle();
      reset = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   task automatic run_scen(input int id, input int ncyc);
      logic [10:0] ev;
      logic [10:0] ov;
      logic        eo;
      logic [3:0]  em;
      for (int c = 0; c < ncyc; c++) begin
         drive_idle();
         case (id)
            1: smp_valid = (c == 0);
            2: begin
               smp_valid = (c == 0) || (c == 4) || (c == 10) || (c == 13);
               ovr_clr   = (c == 10) || (c == 13) || (c == 16);
            end
            3: begin
               smp_valid = (c == 0);
               mu_ld     = (c == 3) || (c == 7) || (c == 11) || (c == 13);
               mu_in     = (c == 3) ? 4'd2 : (c == 7) ? 4'd5 : (c == 11) ? 4'd15 : 4'd11;
            end
            4: begin
               smp_valid = (c == 0) || (c == 4);
               en        = !(c >= 3 && c <= 5);
            end
            5: begin
               smp_valid = (c == 0) || (c == 4) || (c == 12);
               mu_ld     = (c == 2);
               mu_in     = 4'd3;
               reset     = (c == 7);
            end
`ifdef ANC_FREEZE_EN
            6: begin
               smp_valid = (c == 0);
               wfreeze   = 1'b1;
            end
`endif
            default: ;
         endcase

         @(negedge clk);
         ev = 11'b0;
         eo = 1'b0;
         em = 4'd8;
         case (id)
            1: ev = nom(c);
            2: begin
               ev = (c < 10) ? nom(c) : nom(c - 10);
               eo = (c >= 5 && c <= 10) || (c >= 14 && c <= 16);
            end
            3: begin
               ev = nom(c);
               em = (c <= 9) ? 4'd8 : (c <= 11) ? 4'd5 : (c <= 13) ? 4'd12 : 4'd11;
            end
            4: ev = (c < 3) ? nom(c) : (c <= 5) ? 11'b000000_1_0001 : nom(c - 3);
            5: begin
               ev = (c <= 7) ? nom(c) : (c < 12) ? 11'b0 : nom(c - 12);
               eo = (c >= 5 && c <= 7);
            end
            6: ev = (c <= 5) ? nom(c) : (c == 6) ? 11'b000001_1_0000 : 11'b0;
            default: ;
         endcase
         ov = {shift_en, mac_en, mac_clr, err_ld, wupd_en, anc_valid, busy, tap_addr};
         check_eq($sformatf("s%0d_c%0d_strobes", id, c), {21'b0, ov}, {21'b0, ev});
         check_eq($sformatf("s%0d_c%0d_overrun", id, c), {31'b0, overrun}, {31'b0, eo});
         check_eq($sformatf("s%0d_c%0d_mu_out", id, c), {28'b0, mu_out}, {28'b0, em});
         @(posedge clk);
         #1;
      end
      drive_idle();
   endtask

   initial begin
      do_reset();
      check_eq("reset_strobes",
               {21'b0, shift_en, mac_en, mac_clr, err_ld, wupd_en, anc_valid, busy, tap_addr},
               32'd0);
      check_eq("reset_overrun", {31'b0, overrun}, 32'd0);
      check_eq("reset_mu_out", {28'b0, mu_out}, 32'd8);

      run_scen(1, 11);
      do_reset();
      run_scen(2, 21);
      do_reset();
      run_scen(3, 15);
      do_reset();
      run_scen(4, 14);
      do_reset();
      run_scen(5, 23);
`ifdef ANC_FREEZE_EN
      do_reset();
      run_scen(6, 9);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/anc_tap_sched.md
Name: anc_tap_sched

Overview:
- Sequencing controller for a time-multiplexed adaptive noise canceller (ANC) FIR/LMS datapath.
- Replaces free-running clkdv-phase control with explicit per-sample strobes, all in the single clk domain.
- Per accepted sample, in order: shift delay lines, run the filter MAC over NTAP taps, latch the error, run the NTAP weight updates, flag output valid.
- Also owns the Mu (step-size shift) configuration register.

Parameters:
NTAP, 3, number of filter taps (1..16)
AW, 4, tap address width; requires 2^AW >= NTAP
W2, 4, Mu width
MU_RST, 8, Mu reset value
MU_MAX, 12, Mu upper clamp

Ports:
clk  in  1  system clock (10 MHz)
reset  in  1  synchronous reset, active high
en  in  1  global enable; 0 freezes the controller
smp_valid  in  1  one-cycle pulse: new Rn/Sn sample present
mu_in  in  W2  requested Mu
mu_ld  in  1  load request for mu_in
ovr_clr  in  1  clears the overrun flag
shift_en  out  1  shift the Rn/Sn delay lines
tap_addr  out  AW  current tap index
mac_clr  out  1  clear the filter accumulator
mac_en  out  1  accumulate W[tap]*R[tap]
err_ld  out  1  latch error = Sn - accumulator into the Ancout register
wupd_en  out  1  update W[tap] += R[tap]*err>>Mu
mu_out  out  W2  active Mu
anc_valid  out  1  Ancout updated this cycle
busy  out  1  controller not in IDLE
overrun  out  1  sticky: a sample arrived while busy

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset state:
  - FSM goes to IDLE; tap_addr=0.
  - All strobes, busy and overrun are 0.
  - mu_out=MU_RST; any pending Mu load is cleared.
  - A reset mid-sequence aborts it: no anc_valid is produced, and datapath contents are not touched by this block.
- FSM: IDLE -> SHIFT -> FILT -> ERR -> UPD -> DONE -> IDLE.
  - IDLE: on smp_valid&en, go to SHIFT.
  - SHIFT (1 cycle): shift_en=1.
  - FILT (NTAP cycles): mac_en=1, tap_addr steps 0..NTAP-1. mac_clr=1 only in the tap-0 cycle; the MAC loads rather than adds on that cycle.
  - ERR (1 cycle): err_ld=1, tap_addr=0.
  - UPD (NTAP cycles): wupd_en=1, tap_addr steps 0..NTAP-1.
  - DONE (1 cycle): anc_valid=1.
- Strobes are registered outputs and are one-hot across shift_en, mac_en, err_ld, wupd_en and anc_valid.
- Latency: with smp_valid sampled at edge 0, shift_en is high in cycle 1 and anc_valid in cycle 2*NTAP+3.
- Throughput: minimum sample spacing is 2*NTAP+4 cycles. A smp_valid in the cycle after DONE (back in IDLE) is accepted.
- busy=1 in every state except IDLE, DONE included.
- Overrun:
  - smp_valid&en while busy is ignored: the sequence is unaffected and overrun is set.
  - overrun holds until ovr_clr. If ovr_clr and a new overrun occur in the same cycle, set wins.
- en=0:
  - State, tap_addr and counters hold; all strobes are forced to 0.
  - smp_valid is ignored without setting overrun.
  - On en returning to 1, the sequence resumes at the held tap with mac_clr not re-issued unless held at tap 0 of FILT.
- Mu:
  - mu_ld in IDLE: mu_out takes min(mu_in, MU_MAX) at the next edge.
  - mu_ld while busy: the clamped value is stored as pending (last request wins) and applied on the edge that enters IDLE. mu_out never changes during UPD.
- tap_addr wraps only by FSM exit; values >= NTAP are never driven.

Optional Feature:
- Macro: ANC_FREEZE_EN.
- Defined:
  - Adds input port wfreeze (1 bit), sampled in ERR.
  - If wfreeze=1, ERR goes directly to DONE: no wupd_en, weights frozen, anc_valid in cycle NTAP+3.
  - If wfreeze=0, the sequence is normal.
- Not defined: the port is absent and UPD always runs.

Test Plan:
1. Nominal timing: NTAP=3, reset, single smp_valid at cycle 0 -> shift_en@1; mac_en@2-4 with tap_addr 0,1,2; mac_clr@2; err_ld@5; wupd_en@6-8 with tap_addr 0,1,2; anc_valid@9; busy@1-9.
2. Overrun: second smp_valid at cycle 4 -> overrun=1 from cycle 5 and timing identical to scenario 1; then ovr_clr -> overrun=0; a smp_valid at cycle 10 is accepted (shift_en@11).
3. Mu loading: mu_ld with mu_in=5 at cycle 3 -> mu_out=8 through cycle 9, 5 from cycle 10. In IDLE, mu_ld with mu_in=15 -> mu_out=12.
4. Enable stall: en=0 for cycles 3-5 (FILT tap 1) -> all strobes 0 and tap_addr=1 held; mac_en resumes at tap 1; anc_valid@12.
5. Reset mid-sequence: reset at cycle 7 (UPD) -> cycle 8 IDLE with all outputs 0 and no anc_valid; a following smp_valid gives nominal timing.
6. Freeze (ANC_FREEZE_EN, wfreeze=1): single sample -> wupd_en never asserts, anc_valid@6, busy deasserts @7.
